// File: rtl/dram_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// dram_arbiter_pkg
// Shared definitions for the multi-core data-RAM arbiter and the processor
// cores that sit on it.
//   arb_state_e : arbiter FSM state encoding
//   DEF_ADDR_W  : default data-memory word address width
//   DEF_DATA_W  : default data word width
//   MIN_CORES / MAX_CORES : supported range of requesting cores
//   rr_next()   : round-robin successor of a core index
// ---------------------------------------------------------------------------
package dram_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_RD_WAIT = 2'd2
  } arb_state_e;

  localparam int DEF_ADDR_W = 12;
  localparam int DEF_DATA_W = 32;
  localparam int MIN_CORES  = 2;
  localparam int MAX_CORES  = 8;

  // Index that follows idx in a ring of n cores.
  function automatic int rr_next(input int idx, input int n);
    return (idx >= n - 32'sd1) ? 32'sd0 : idx + 32'sd1;
  endfunction

endpackage

// File: rtl/dram_arbiter_rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
// Combinational round-robin selector. Scans the request vector starting at
// core ptr in ascending order, wrapping from NUM_CORES-1 back to 0, and
// reports the first requesting core.
//   req   : per-core request vector
//   ptr   : core index where the search starts
//   grant : one-hot vector of the selected core (all zero if none)
//   idx   : index of the selected core (0 if none)
//   any   : at least one request present
// ---------------------------------------------------------------------------
module rr_pick #(
  parameter int NUM_CORES = 4,
  parameter int IDX_W     = 2
) (
  input  logic [NUM_CORES-1:0] req,
  input  logic [IDX_W-1:0]     ptr,
  output logic [NUM_CORES-1:0] grant,
  output logic [IDX_W-1:0]     idx,
  output logic                 any
);

  localparam logic [NUM_CORES-1:0] ONE_HOT_BASE = {{(NUM_CORES-1){1'b0}}, 1'b1};

  int               cand_s;
  logic [IDX_W-1:0] cand_idx_s;
  logic             hit_s;
  logic             found_s;

  // Walk the ring from ptr and keep the first requester encountered.
  always_comb begin
    cand_s     = 32'sd0;
    cand_idx_s = '0;
    hit_s      = 1'b0;
    found_s    = 1'b0;
    idx        = '0;
    for (int off = 32'sd0; off < NUM_CORES; off++) begin
      cand_s     = int'(ptr) + off;
      // ptr and off are both below NUM_CORES, so one subtraction wraps it.
      cand_s     = (cand_s >= NUM_CORES) ? (cand_s - NUM_CORES) : cand_s;
      cand_idx_s = IDX_W'(cand_s);
      hit_s      = ~found_s & req[cand_idx_s];
      idx        = hit_s ? cand_idx_s : idx;
      found_s    = found_s | hit_s;
    end
    grant = found_s ? (ONE_HOT_BASE << idx) : '0;
    any   = found_s;
  end

endmodule

// File: rtl/dram_arbiter.sv
// ---------------------------------------------------------------------------
// dram_arbiter
// Round-robin arbiter that lets NUM_CORES cores share one synchronous data
// RAM. One access is in flight at a time: a winner is chosen in IDLE, the
// RAM command is issued (and the core acknowledged) on the way out of ISSUE,
// and for reads the response is flagged on the way out of RD_WAIT, when the
// RAM's one-cycle read data is on mem_rdata.
// Ports:
//   clk, rst_n           : clock, asynchronous active-low reset
//   req_valid/we/addr/wdata : per-core requests (core i in slice i)
//   req_ready            : one-hot acceptance of a request
//   rsp_valid, rsp_rdata : one-hot read response and shared read data
//   mem_en/we/addr/wdata : RAM command, mem_rdata : RAM read data
//   core_end, all_done   : per-core End flags and sticky all-finished flag
// ---------------------------------------------------------------------------
module dram_arbiter
  import dram_arbiter_pkg::*;
#(
  parameter int NUM_CORES = 4,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DATA_W    = DEF_DATA_W
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_CORES-1:0]        req_valid,
  input  logic [NUM_CORES-1:0]        req_we,
  input  logic [NUM_CORES*ADDR_W-1:0] req_addr,
  input  logic [NUM_CORES*DATA_W-1:0] req_wdata,
  output logic [NUM_CORES-1:0]        req_ready,
  output logic [NUM_CORES-1:0]        rsp_valid,
  output logic [DATA_W-1:0]           rsp_rdata,
  output logic                        mem_en,
  output logic                        mem_we,
  output logic [ADDR_W-1:0]           mem_addr,
  output logic [DATA_W-1:0]           mem_wdata,
  input  logic [DATA_W-1:0]           mem_rdata,
  input  logic [NUM_CORES-1:0]        core_end,
  output logic                        all_done
);

  localparam int IDX_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

  if (NUM_CORES < MIN_CORES || NUM_CORES > MAX_CORES) begin : g_bad_num_cores
    $error("dram_arbiter: NUM_CORES must be within 2..8");
  end

  arb_state_e           state_r;
  logic [IDX_W-1:0]     ptr_r;
  logic [IDX_W-1:0]     winner_r;
  logic [NUM_CORES-1:0] winner_oh_r;
  logic [NUM_CORES-1:0] req_ready_r;
  logic [NUM_CORES-1:0] rsp_valid_r;
  logic                 mem_en_r;
  logic                 mem_we_r;
  logic [ADDR_W-1:0]    mem_addr_r;
  logic [DATA_W-1:0]    mem_wdata_r;
  logic                 all_done_r;

  logic [NUM_CORES-1:0] pick_req_s;
  logic [NUM_CORES-1:0] pick_grant_s;
  logic [IDX_W-1:0]     pick_idx_s;
  logic                 pick_any_s;
  logic [IDX_W-1:0]     ptr_next_s;
  logic                 win_we_s;
  logic [ADDR_W-1:0]    win_addr_s;
  logic [DATA_W-1:0]    win_wdata_s;

  // The core acknowledged last cycle is still holding req_valid during the
  // handshake cycle; hide it so it cannot be granted twice for one request.
  assign pick_req_s = req_valid & ~req_ready_r;

  rr_pick #(
    .NUM_CORES (NUM_CORES),
    .IDX_W     (IDX_W)
  ) u_rr_pick (
    .req   (pick_req_s),
    .ptr   (ptr_r),
    .grant (pick_grant_s),
    .idx   (pick_idx_s),
    .any   (pick_any_s)
  );

  assign ptr_next_s  = IDX_W'(rr_next(int'(pick_idx_s), NUM_CORES));
  assign win_we_s    = req_we[winner_r];
  assign win_addr_s  = req_addr[int'(winner_r)*ADDR_W +: ADDR_W];
  assign win_wdata_s = req_wdata[int'(winner_r)*DATA_W +: DATA_W];

  // Arbitration FSM with registered grant, RAM command and response flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      ptr_r       <= '0;
      winner_r    <= '0;
      winner_oh_r <= '0;
      req_ready_r <= '0;
      rsp_valid_r <= '0;
      mem_en_r    <= 1'b0;
      mem_we_r    <= 1'b0;
      mem_addr_r  <= '0;
      mem_wdata_r <= '0;
    end else begin
      req_ready_r <= '0;
      rsp_valid_r <= '0;
      mem_en_r    <= 1'b0;
      mem_we_r    <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (pick_any_s) begin
            winner_r    <= pick_idx_s;
            winner_oh_r <= pick_grant_s;
            ptr_r       <= ptr_next_s;
            state_r     <= ST_ISSUE;
          end else begin
            state_r     <= ST_IDLE;
          end
        end
        ST_ISSUE: begin
          req_ready_r <= winner_oh_r;
          mem_en_r    <= 1'b1;
          mem_we_r    <= win_we_s;
          mem_addr_r  <= win_addr_s;
          mem_wdata_r <= win_wdata_s;
          state_r     <= win_we_s ? ST_IDLE : ST_RD_WAIT;
        end
        ST_RD_WAIT: begin
          // The RAM samples the read command on this edge; its data is on
          // mem_rdata for the cycle in which rsp_valid is high.
          rsp_valid_r <= winner_oh_r;
          state_r     <= ST_IDLE;
        end
        default: begin
          state_r     <= ST_IDLE;
        end
      endcase
    end
  end

  // Sticky completion flag: once every core has signalled End it stays set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      all_done_r <= 1'b0;
    end else begin
      all_done_r <= all_done_r | (&core_end);
    end
  end

  assign req_ready = req_ready_r;
  assign rsp_valid = rsp_valid_r;
  assign mem_en    = mem_en_r;
  assign mem_we    = mem_we_r;
  assign mem_addr  = mem_addr_r;
  assign mem_wdata = mem_wdata_r;
  assign all_done  = all_done_r;
  // Read data comes straight from the RAM; it is forced to zero outside a
  // response so the shared bus is quiet (and zero in reset).
  assign rsp_rdata = (|rsp_valid_r) ? mem_rdata : '0;

endmodule

// File: tb/tb_dram_arbiter.sv
// ---------------------------------------------------------------------------
// tb_dram_arbiter
// Self-checking bench for dram_arbiter (4 cores). A transaction-level model
// tracks when the shared RAM is free, which core the round-robin rule picks,
// the resulting grant/response cycles and the expected memory contents.
// Directed scenarios are followed by a randomized phase.
// ---------------------------------------------------------------------------
module tb_dram_arbiter;

  localparam int N  = 4;
  localparam int AW = 12;
  localparam int DW = 32;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_we;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic [N-1:0]    req_ready;
  logic [N-1:0]    rsp_valid;
  logic [DW-1:0]   rsp_rdata;
  logic            mem_en;
  logic            mem_we;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_wdata;
  logic [DW-1:0]   mem_rdata;
  logic [N-1:0]    core_end;
  logic            all_done;

  dram_arbiter #(.NUM_CORES(N), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .core_end  (core_end),
    .all_done  (all_done)
  );

  always #5 clk = ~clk;

  // Synchronous data RAM: read data valid the cycle after a read command.
  logic [DW-1:0] ram [0:(1<<AW)-1];
  logic [DW-1:0] ram_q = 32'd0;
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        ram_q <= ram[mem_addr];
    end
  end
  assign mem_rdata = ram_q;

  // Reference state
  logic [DW-1:0] ref_mem [0:(1<<AW)-1];
  int            checks = 0;
  int            failures = 0;
  int            cyc = 0;
  int            next_sample = 0;
  int            g_edge = -1;
  int            r_edge = -1;
  int            g_core = 0;
  int            m_ptr = 0;
  logic          g_we = 1'b0;
  logic [AW-1:0] g_addr = '0;
  logic [DW-1:0] g_wdata = '0;
  logic          m_done = 1'b0;
  logic [N-1:0]  exp_ready = '0;
  logic [N-1:0]  exp_rsp = '0;
  logic          exp_en = 1'b0;
  logic          exp_we = 1'b0;
  logic [AW-1:0] exp_addr = '0;
  logic [DW-1:0] exp_wdata = '0;
  logic [DW-1:0] exp_rdata = '0;
  logic [N-1:0]  pulse = '0;
  logic          auto_en = 1'b0;
  int            grant_q[$];
  int            rsp_seen = 0;

  function automatic logic [DW-1:0] init_word(input int a);
    return 32'hC0DE_0000 ^ (32'(a) * 32'h0001_0101);
  endfunction

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    if (obs !== expv) begin
      failures++;
      $display("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, expv, cyc);
    end
  endtask

  task automatic check_reset(input string p);
    check_val({p, "_ready"}, 64'(req_ready), 64'd0);
    check_val({p, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
    check_val({p, "_rsp_rdata"}, 64'(rsp_rdata), 64'd0);
    check_val({p, "_mem_en"}, 64'(mem_en), 64'd0);
    check_val({p, "_mem_we"}, 64'(mem_we), 64'd0);
    check_val({p, "_mem_addr"}, 64'(mem_addr), 64'd0);
    check_val({p, "_mem_wdata"}, 64'(mem_wdata), 64'd0);
    check_val({p, "_all_done"}, 64'(all_done), 64'd0);
  endtask

  task automatic model_reset();
    m_ptr = 0; next_sample = 0; g_edge = -1; r_edge = -1; m_done = 1'b0;
    exp_ready = '0; exp_rsp = '0; exp_en = 1'b0; exp_we = 1'b0;
  endtask

  // One access at a time: a pick needs a free RAM; a write occupies it for
  // 2 cycles (grant one cycle after the pick), a read for 3 (data after that).
  task automatic model_step();
    cyc++;
    exp_ready = '0; exp_rsp = '0; exp_en = 1'b0; exp_we = 1'b0;
    if (rst_n) begin
      m_done = m_done | (&core_end);
      if (cyc == g_edge) begin
        exp_ready[g_core] = 1'b1;
        exp_en = 1'b1; exp_we = g_we; exp_addr = g_addr; exp_wdata = g_wdata;
        if (g_we) ref_mem[g_addr] = g_wdata;
        else      r_edge = cyc + 1;
      end
      if (cyc == r_edge) begin
        exp_rsp[g_core] = 1'b1;
        exp_rdata = ref_mem[g_addr];
      end
      if (cyc >= next_sample && req_valid != '0) begin
        int w;
        w = -1;
        for (int off = 0; off < N; off++) begin
          int c;
          c = (m_ptr + off) % N;
          if (w < 0 && req_valid[c]) w = c;
        end
        m_ptr = (w + 1) % N;
        g_core = w; g_edge = cyc + 1;
        g_we = req_we[w];
        g_addr = req_addr[w*AW +: AW];
        g_wdata = req_wdata[w*DW +: DW];
        next_sample = cyc + (g_we ? 2 : 3);
      end
    end
  endtask

  task automatic compare();
    check_val("req_ready", 64'(req_ready), 64'(exp_ready));
    check_val("rsp_valid", 64'(rsp_valid), 64'(exp_rsp));
    check_val("mem_en", 64'(mem_en), 64'(exp_en));
    check_val("mem_we", 64'(mem_we), 64'(exp_we));
    check_val("all_done", 64'(all_done), 64'(m_done));
    if (exp_en) check_val("mem_addr", 64'(mem_addr), 64'(exp_addr));
    if (exp_en && exp_we) check_val("mem_wdata", 64'(mem_wdata), 64'(exp_wdata));
    if (exp_rsp != '0) check_val("rsp_rdata", 64'(rsp_rdata), 64'(exp_rdata));
    for (int i = 0; i < N; i++) if (req_ready[i]) grant_q.push_back(i);
    if (rsp_valid != '0) rsp_seen++;
  endtask

  task automatic raise(input int i, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_valid[i] = 1'b1; req_we[i] = we;
    req_addr[i*AW +: AW] = a; req_wdata[i*DW +: DW] = d;
  endtask

  task automatic tick();
    logic [N-1:0] dropped;
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare();
    dropped = '0;
    for (int i = 0; i < N; i++) begin
      if (pulse[i] || exp_ready[i]) begin
        req_valid[i] = 1'b0; pulse[i] = 1'b0; dropped[i] = 1'b1;
      end
    end
    if (auto_en) begin
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i] && !dropped[i]) begin
          if ($urandom_range(0, 3) == 32'd0) begin
            raise(i, 1'($urandom), AW'($urandom_range(0, 15)), $urandom);
          end else if (cyc + 1 < next_sample && $urandom_range(0, 7) == 32'd0) begin
            // Short-lived request that never overlaps an arbitration point.
            raise(i, 1'($urandom), AW'($urandom_range(0, 15)), $urandom);
            pulse[i] = 1'b1;
          end
        end
      end
      if ($urandom_range(0, 63) == 32'd0) core_end = 4'($urandom);
    end
  endtask

  task automatic do_reset(input string p);
    rst_n = 1'b0;
    req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0;
    core_end = '0; pulse = '0;
    model_reset();
    #1;
    check_reset(p);
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    for (int a = 0; a < (1 << AW); a++) begin
      ram[a] = init_word(a);
      ref_mem[a] = init_word(a);
    end
    req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0; core_end = '0;
    @(negedge clk);
    do_reset("rst");

    // Single write by core 2, then a read of it by core 0.
    raise(2, 1'b1, 12'h010, 32'hDEADBEEF);
    tick(); tick();
    check_val("wr_grant_c2", 64'(req_ready), 64'h4);
    check_val("wr_mem_we", 64'(mem_we), 64'h1);
    check_val("wr_mem_addr", 64'(mem_addr), 64'h010);
    tick();
    raise(0, 1'b0, 12'h010, 32'h0);
    tick(); tick(); tick();
    check_val("rd_rsp_c0", 64'(rsp_valid), 64'h1);
    check_val("rd_data", 64'(rsp_rdata), 64'hDEADBEEF);
    tick();

    // All four cores read at once straight out of reset.
    do_reset("rst2");
    for (int i = 0; i < N; i++) raise(i, 1'b0, AW'(4 * i), 32'h0);
    grant_q.delete();
    repeat (13) tick();
    check_val("contend_n", 64'(grant_q.size()), 64'd4);
    for (int i = 0; i < 4; i++)
      if (i < grant_q.size()) check_val("contend_order", 64'(grant_q[i]), 64'(i));

    // Pointer at 3, then cores 0 and 3 contend: 3 wins first.
    do_reset("rst3");
    raise(2, 1'b1, 12'h020, 32'h1234_5678);
    tick(); tick(); tick();
    raise(0, 1'b1, 12'h030, 32'hAAAA_0000);
    raise(3, 1'b1, 12'h033, 32'hBBBB_3333);
    grant_q.delete();
    repeat (6) tick();
    check_val("wrap_n", 64'(grant_q.size()), 64'd2);
    if (grant_q.size() == 2) begin
      check_val("wrap_first", 64'(grant_q[0]), 64'd3);
      check_val("wrap_second", 64'(grant_q[1]), 64'd0);
    end

    // Core 1 pulses while core 0 is being served: it must never be granted.
    raise(0, 1'b0, 12'h030, 32'h0);
    grant_q.delete();
    tick();
    raise(1, 1'b1, 12'h031, 32'h5555_5555);
    pulse[1] = 1'b1;
    repeat (6) tick();
    check_val("withdraw_n", 64'(grant_q.size()), 64'd1);
    if (grant_q.size() == 1) check_val("withdraw_who", 64'(grant_q[0]), 64'd0);

    // Reset while a read is waiting for RAM data.
    raise(1, 1'b0, 12'h033, 32'h0);
    tick(); tick();
    check_val("rdw_grant_c1", 64'(req_ready), 64'h2);
    do_reset("rst_rdw");
    rsp_seen = 0;
    repeat (4) tick();
    check_val("rdw_no_rsp", 64'(rsp_seen), 64'd0);

    // End detection and stickiness.
    core_end = 4'b0001; tick();
    check_val("end_0001", 64'(all_done), 64'd0);
    core_end = 4'b0111; tick();
    check_val("end_0111", 64'(all_done), 64'd0);
    core_end = 4'b1111; tick();
    check_val("end_1111", 64'(all_done), 64'd1);
    core_end = 4'b0000; tick(); tick();
    check_val("end_sticky", 64'(all_done), 64'd1);

    // Randomized traffic, then drain the requests still held.
    do_reset("rst_rand");
    auto_en = 1'b1;
    repeat (3000) tick();
    auto_en = 1'b0;
    repeat (40) tick();
    check_val("drain_idle", 64'(req_valid), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
